// File: rtl/lwe_dot_mod_accum.sv
// lwe_dot_mod_accum: sequences a[i]*s[i] mod Q through an external multiplier, accumulates mod Q, adds err.
module lwe_dot_mod_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int n_WIDTH = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [n_WIDTH-1:0]    len,
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic [DATA_WIDTH-1:0] err,
  output logic [n_WIDTH-1:0]    idx,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] s_in,
  output logic                  mul_start,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  output logic [DATA_WIDTH-1:0] mul_Q,
  input  logic [DATA_WIDTH-1:0] mul_result,
  input  logic                  mul_done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ready,
  output logic                  done
`ifdef ACC_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, FETCH, MUL, WAIT, ACC, ERR, DONE} state_t;
  state_t state, next;
  logic [n_WIDTH-1:0] len_r;
  logic [W-1:0] err_r, acc, p, p_mod, e_mod;
  logic [W:0] sum, esum;
  logic wd_hit;
  function automatic logic [W-1:0] red(input logic [W:0] x, input logic [W-1:0] q);
    return x >= {1'b0, q} ? W'(x - {1'b0, q}) : x[W-1:0];
  endfunction
  assign ready = state == IDLE;
  assign p_mod = mul_result[W-1] ? mul_result + mul_Q : mul_result;
  assign e_mod = err_r[W-1] ? err_r + mul_Q : err_r;
  assign sum   = {1'b0, acc} + {1'b0, p};
  assign esum  = {1'b0, acc} + {1'b0, e_mod};
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? (len == '0 ? ERR : FETCH) : IDLE;
      FETCH:   next = MUL;
      MUL:     next = WAIT;
      WAIT:    next = mul_done ? ACC : (wd_hit ? DONE : WAIT);
      ACC:     next = idx == len_r - 1'b1 ? ERR : FETCH;
      ERR:     next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_Q     <= '0;
      result    <= '0;
      acc       <= '0;
      p         <= '0;
      len_r     <= '0;
      err_r     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= next;
      mul_start <= state == FETCH;
      done      <= state == DONE;
      case (state)
        IDLE: if (start) begin
          len_r <= len;
          mul_Q <= Q;
          err_r <= err;
          acc   <= '0;
          idx   <= '0;
        end
        FETCH: begin
          mul_a <= a_in;
          mul_b <= s_in;
        end
        WAIT: if (mul_done) p <= p_mod; else if (wd_hit) result <= '0;
        ACC: begin
          acc <= red(sum, mul_Q);
          if (next == FETCH) idx <= idx + 1'b1;
        end
        ERR: result <= red(esum, mul_Q);
        default: ;
      endcase
    end
  end
`ifdef ACC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wcnt;
  assign wd_hit = state == WAIT && !mul_done && wcnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      wcnt    <= state == WAIT ? wcnt + 1'b1 : '0;
      timeout <= (state == IDLE && start) ? 1'b0 : (timeout | wd_hit);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif
endmodule
